ps2_ascii_scanner: RTL and testbench

PS2_ASCII_SCANNER -- requirements
Module: ps2_ascii_scanner

---
 rtl/ps2_ascii_scanner_pkg.sv | 19 +
 rtl/ps2_scan2ascii.sv | 56 +++++
 rtl/ps2_ascii_scanner.sv | 164 ++++++++++++++++
 tb/tb_ps2_ascii_scanner.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_ascii_scanner_pkg.sv
// Shared definitions for the PS/2 scancode-to-ASCII scanner: receiver states,
// protocol byte values and the default key RAM address.
package ps2_ascii_scanner_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0]  SC_BREAK  = 8'hF0;
    localparam logic [7:0]  SC_EXT    = 8'hE0;
    localparam logic [7:0]  SC_LSHIFT = 8'h12;
    localparam logic [7:0]  SC_RSHIFT = 8'h59;

    localparam logic [12:0] SCAN_ASCII_ADDR_DEFAULT = 13'h0310;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Scan code set 2 to ASCII lookup for letters, digits, space and enter.
// Shift selects upper case letters and the US symbols above the digit row.
module ps2_scan2ascii
    import ps2_ascii_scanner_pkg::*;
(
    input  logic [7:0] scancode,
    input  logic       shift,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (scancode)
            8'h1C: ascii = shift ? "A" : "a";
            8'h32: ascii = shift ? "B" : "b";
            8'h21: ascii = shift ? "C" : "c";
            8'h23: ascii = shift ? "D" : "d";
            8'h24: ascii = shift ? "E" : "e";
            8'h2B: ascii = shift ? "F" : "f";
            8'h34: ascii = shift ? "G" : "g";
            8'h33: ascii = shift ? "H" : "h";
            8'h43: ascii = shift ? "I" : "i";
            8'h3B: ascii = shift ? "J" : "j";
            8'h42: ascii = shift ? "K" : "k";
            8'h4B: ascii = shift ? "L" : "l";
            8'h3A: ascii = shift ? "M" : "m";
            8'h31: ascii = shift ? "N" : "n";
            8'h44: ascii = shift ? "O" : "o";
            8'h4D: ascii = shift ? "P" : "p";
            8'h15: ascii = shift ? "Q" : "q";
            8'h2D: ascii = shift ? "R" : "r";
            8'h1B: ascii = shift ? "S" : "s";
            8'h2C: ascii = shift ? "T" : "t";
            8'h3C: ascii = shift ? "U" : "u";
            8'h2A: ascii = shift ? "V" : "v";
            8'h1D: ascii = shift ? "W" : "w";
            8'h22: ascii = shift ? "X" : "x";
            8'h35: ascii = shift ? "Y" : "y";
            8'h1A: ascii = shift ? "Z" : "z";
            8'h45: ascii = shift ? ")" : "0";
            8'h16: ascii = shift ? "!" : "1";
            8'h1E: ascii = shift ? "@" : "2";
            8'h26: ascii = shift ? "#" : "3";
            8'h25: ascii = shift ? "$" : "4";
            8'h2E: ascii = shift ? "%" : "5";
            8'h36: ascii = shift ? "^" : "6";
            8'h3D: ascii = shift ? "&" : "7";
            8'h3E: ascii = shift ? "*" : "8";
            8'h46: ascii = shift ? "(" : "9";
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_ascii_scanner.sv
// PS/2 keyboard receiver that keeps the ASCII code of the currently held key
// at a fixed key RAM address, with framing and timeout error reporting.
module ps2_ascii_scanner
    import ps2_ascii_scanner_pkg::*;
#(
    parameter logic [12:0] SCAN_ASCII_ADDR = SCAN_ASCII_ADDR_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES  = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [12:0] key_ram_addr,
    output logic [31:0] key_ram_wdata,
    output logic        key_ram_wen,
    output logic        frame_error
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0] ps2_raw;
    logic [1:0] ps2_sync;
    logic       ps2_clk_prev_reg;
    logic       ps2_fall;

    assign ps2_raw = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= ps2_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign ps2_sync[gi] = sync_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) ps2_clk_prev_reg <= 1'b1;
        else       ps2_clk_prev_reg <= ps2_sync[0];
    end

    assign ps2_fall = !ps2_sync[0] && ps2_clk_prev_reg;

    rx_state_t         state_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        rx_shift_reg;
    logic              parity_reg;
    logic [TO_W-1:0]   timeout_reg;
    logic              byte_valid_reg;
    logic [7:0]        byte_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= RX_IDLE;
            bit_cnt_reg    <= 3'd0;
            rx_shift_reg   <= 8'd0;
            parity_reg     <= 1'b0;
            timeout_reg    <= '0;
            byte_valid_reg <= 1'b0;
            byte_reg       <= 8'd0;
            frame_error    <= 1'b0;
        end else begin
            frame_error    <= 1'b0;
            byte_valid_reg <= 1'b0;

            if (state_reg == RX_IDLE || ps2_fall) timeout_reg <= '0;
            else                                  timeout_reg <= timeout_reg + TO_W'(1);

            // A stalled partial frame is dropped so the next start bit resynchronises.
            if (state_reg != RX_IDLE && !ps2_fall &&
                timeout_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_reg   <= RX_IDLE;
                bit_cnt_reg <= 3'd0;
                frame_error <= 1'b1;
                timeout_reg <= '0;
            end else if (ps2_fall) begin
                case (state_reg)
                    RX_IDLE: begin
                        if (!ps2_sync[1]) begin
                            state_reg    <= RX_DATA;
                            bit_cnt_reg  <= 3'd0;
                            rx_shift_reg <= 8'd0;
                        end
                    end
                    RX_DATA: begin
                        rx_shift_reg <= {ps2_sync[1], rx_shift_reg[7:1]};
                        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) state_reg <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        parity_reg <= ps2_sync[1];
                        state_reg  <= RX_STOP;
                    end
                    RX_STOP: begin
                        state_reg <= RX_IDLE;
                        byte_reg  <= rx_shift_reg;
                        if (ps2_sync[1] && (^{rx_shift_reg, parity_reg})) byte_valid_reg <= 1'b1;
                        else                                              frame_error    <= 1'b1;
                    end
                    default: state_reg <= RX_IDLE;
                endcase
            end
        end
    end

    logic       break_pending_reg;
    logic       ext_pending_reg;
    logic       shift_reg;
    logic [7:0] held_code_reg;
    logic [7:0] ascii;

    ps2_scan2ascii u_scan2ascii (
        .scancode (byte_reg),
        .shift    (shift_reg),
        .ascii    (ascii)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            break_pending_reg <= 1'b0;
            ext_pending_reg   <= 1'b0;
            shift_reg         <= 1'b0;
            held_code_reg     <= 8'd0;
            key_ram_wen       <= 1'b0;
            key_ram_wdata     <= 32'd0;
        end else if (byte_valid_reg) begin
            if (byte_reg == SC_BREAK) begin
                break_pending_reg <= 1'b1;
            end else if (byte_reg == SC_EXT) begin
                ext_pending_reg <= 1'b1;
            end else begin
                break_pending_reg <= 1'b0;
                ext_pending_reg   <= 1'b0;
                if (byte_reg == SC_LSHIFT || byte_reg == SC_RSHIFT) begin
                    shift_reg <= !break_pending_reg;
                end else if (break_pending_reg) begin
                    if (byte_reg == held_code_reg) begin
                        key_ram_wen   <= 1'b0;
                        key_ram_wdata <= 32'd0;
                    end
                end else if (!ext_pending_reg && ascii != 8'd0 &&
                             !(key_ram_wen && byte_reg == held_code_reg)) begin
                    // Typematic repeats are ignored so a later shift change
                    // cannot re-translate the key already being held.
                    key_ram_wen   <= 1'b1;
                    key_ram_wdata <= {24'd0, ascii};
                    held_code_reg <= byte_reg;
                end
            end
        end
    end

    assign key_ram_addr = SCAN_ASCII_ADDR;

endmodule

// File: tb/tb_ps2_ascii_scanner.sv
// Self-checking bench: directed vector table, hand-written timeout/reset
// sequences and random key traffic against a key-event reference model.
module tb_ps2_ascii_scanner;

    localparam int TO = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [12:0] key_ram_addr;
    logic [31:0] key_ram_wdata;
    logic        key_ram_wen;
    logic        frame_error;

    always #5 clock = ~clock;

    ps2_ascii_scanner #(
        .SCAN_ASCII_ADDR (13'h0310),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .key_ram_addr  (key_ram_addr),
        .key_ram_wdata (key_ram_wdata),
        .key_ram_wen   (key_ram_wen),
        .frame_error   (frame_error)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int ferr_seen = 0;

    always @(negedge clock) if (frame_error) ferr_seen++;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};
    string digit_shift = ")!@#$%^&*(";

    logic [7:0] prefix_q [$];
    bit         m_shift;
    bit         m_held;
    logic [7:0] m_code;
    logic [7:0] m_ascii;

    function automatic logic [7:0] ref_ascii(logic [7:0] code, bit sh);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == code) return sh ? 8'(65 + i) : 8'(97 + i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == code) return sh ? digit_shift[i] : 8'(48 + i);
        if (code == 8'h29) return 8'h20;
        if (code == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic model_reset();
        prefix_q.delete();
        m_shift = 0;
        m_held  = 0;
        m_code  = 8'h00;
        m_ascii = 8'h00;
    endtask

    // Bytes are grouped into key events: any prefixes, then one key code.
    task automatic model_feed(logic [7:0] b);
        bit is_brk;
        bit is_ext;
        logic [7:0] a;
        if (b == 8'hF0 || b == 8'hE0) begin
            prefix_q.push_back(b);
            return;
        end
        is_brk = 0;
        is_ext = 0;
        foreach (prefix_q[i]) begin
            if (prefix_q[i] == 8'hF0) is_brk = 1;
            if (prefix_q[i] == 8'hE0) is_ext = 1;
        end
        prefix_q.delete();
        if (b == 8'h12 || b == 8'h59) begin
            m_shift = !is_brk;
        end else if (is_brk) begin
            if (m_held && b == m_code) m_held = 0;
        end else begin
            a = ref_ascii(b, m_shift);
            if (!is_ext && a != 8'h00 && !(m_held && b == m_code)) begin
                m_held  = 1;
                m_code  = b;
                m_ascii = a;
            end
        end
    endtask

    // ---------------- stimulus and checks ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // bad[0] flips the parity bit, bad[1] clears the stop bit.
    task automatic send_bits(logic [7:0] b, logic [1:0] bad, int nbits, bit lat_check);
        logic [10:0] bits;
        bits = {~bad[1], (~^b) ^ bad[0], b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clock); #1 ps2_data = bits[i];
            repeat (4) @(posedge clock);
            #1 ps2_clk = 1'b0;
            if (lat_check && i == 10) begin
                repeat (3) @(posedge clock);
                #1 chk("lat_early_wen", 32'(key_ram_wen), 32'd0);
                @(posedge clock);
                #1 chk("lat_wen", 32'(key_ram_wen), 32'd1);
                chk("lat_wdata", key_ram_wdata, 32'h00000061);
                chk("lat_addr", 32'(key_ram_addr), 32'h0310);
                repeat (4) @(posedge clock);
            end else begin
                repeat (8) @(posedge clock);
            end
            #1 ps2_clk = 1'b1;
        end
        @(posedge clock); #1 ps2_data = 1'b1;
        repeat (6) @(posedge clock);
        #1;
    endtask

    task automatic frame_check(logic [7:0] b, logic [1:0] bad, bit exp_wen,
                               logic [7:0] exp_ascii, bit exp_ferr);
        int f0;
        f0 = ferr_seen;
        send_bits(b, bad, 11, 1'b0);
        chk("wen", 32'(key_ram_wen), 32'(exp_wen));
        chk("wdata", key_ram_wdata, {24'd0, exp_ascii});
        chk("addr", 32'(key_ram_addr), 32'h0310);
        chk("ferr_count", 32'(ferr_seen - f0), 32'(exp_ferr));
        $display("frame %02h bad=%0d wen=%0d wdata=%08h ferr=%0d",
                 b, bad, key_ram_wen, key_ram_wdata, ferr_seen - f0);
    endtask

    typedef struct {
        logic [7:0] code;
        logic [1:0] bad;
        bit         wen;
        logic [7:0] ascii;
        bit         ferr;
    } vec_t;

    localparam int NV = 40;
    vec_t vecs [NV];

    initial begin
        int f0;
        int r;
        int k;
        logic [7:0] code;
        bit brk;
        bit ext;
        logic [7:0] seq [$];
        logic [1:0] bad;

        vecs = '{
            '{8'hF0, 2'b00, 1'b1, 8'h61, 1'b0}, '{8'h1C, 2'b00, 1'b0, 8'h00, 1'b0},
            '{8'h12, 2'b00, 1'b0, 8'h00, 1'b0}, '{8'h1C, 2'b00, 1'b1, 8'h41, 1'b0},
            '{8'hF0, 2'b00, 1'b1, 8'h41, 1'b0}, '{8'h1C, 2'b00, 1'b0, 8'h00, 1'b0},
            '{8'hF0, 2'b00, 1'b0, 8'h00, 1'b0}, '{8'h12, 2'b00, 1'b0, 8'h00, 1'b0},
            '{8'h1C, 2'b00, 1'b1, 8'h61, 1'b0}, '{8'hF0, 2'b00, 1'b1, 8'h61, 1'b0},
            '{8'h1C, 2'b00, 1'b0, 8'h00, 1'b0}, '{8'h1C, 2'b01, 1'b0, 8'h00, 1'b1},
            '{8'h32, 2'b00, 1'b1, 8'h62, 1'b0}, '{8'h1C, 2'b00, 1'b1, 8'h61, 1'b0},
            '{8'h32, 2'b00, 1'b1, 8'h62, 1'b0}, '{8'hF0, 2'b00, 1'b1, 8'h62, 1'b0},
            '{8'h1C, 2'b00, 1'b1, 8'h62, 1'b0}, '{8'hF0, 2'b00, 1'b1, 8'h62, 1'b0},
            '{8'h32, 2'b00, 1'b0, 8'h00, 1'b0}, '{8'hE0, 2'b00, 1'b0, 8'h00, 1'b0},
            '{8'h1C, 2'b00, 1'b0, 8'h00, 1'b0}, '{8'h1C, 2'b00, 1'b1, 8'h61, 1'b0},
            '{8'h59, 2'b00, 1'b1, 8'h61, 1'b0}, '{8'h1C, 2'b00, 1'b1, 8'h61, 1'b0},
            '{8'hF0, 2'b00, 1'b1, 8'h61, 1'b0}, '{8'h1C, 2'b00, 1'b0, 8'h00, 1'b0},
            '{8'h45, 2'b00, 1'b1, 8'h29, 1'b0}, '{8'hF0, 2'b00, 1'b1, 8'h29, 1'b0},
            '{8'h59, 2'b00, 1'b1, 8'h29, 1'b0}, '{8'h45, 2'b00, 1'b1, 8'h29, 1'b0},
            '{8'hF0, 2'b00, 1'b1, 8'h29, 1'b0}, '{8'h45, 2'b00, 1'b0, 8'h00, 1'b0},
            '{8'h05, 2'b00, 1'b0, 8'h00, 1'b0}, '{8'h5A, 2'b00, 1'b1, 8'h0D, 1'b0},
            '{8'hF0, 2'b00, 1'b1, 8'h0D, 1'b0}, '{8'h5A, 2'b00, 1'b0, 8'h00, 1'b0},
            '{8'h29, 2'b10, 1'b0, 8'h00, 1'b1}, '{8'h29, 2'b00, 1'b1, 8'h20, 1'b0},
            '{8'hF0, 2'b00, 1'b1, 8'h20, 1'b0}, '{8'h29, 2'b00, 1'b0, 8'h00, 1'b0}
        };

        // Reset state
        repeat (3) @(posedge clock);
        #1 chk("rst_wen", 32'(key_ram_wen), 32'd0);
        chk("rst_wdata", key_ram_wdata, 32'd0);
        chk("rst_ferr", 32'(frame_error), 32'd0);
        chk("rst_addr", 32'(key_ram_addr), 32'h0310);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // 'a' appears exactly two cycles after the stop edge is seen
        f0 = ferr_seen;
        send_bits(8'h1C, 2'b00, 11, 1'b1);
        chk("lat_ferr", 32'(ferr_seen - f0), 32'd0);
        $display("frame 1c latency wen=%0d wdata=%08h", key_ram_wen, key_ram_wdata);

        for (int i = 0; i < NV; i++)
            frame_check(vecs[i].code, vecs[i].bad, vecs[i].wen, vecs[i].ascii, vecs[i].ferr);

        // Frame stalls after four data bits
        f0 = ferr_seen;
        send_bits(8'h1C, 2'b00, 5, 1'b0);
        repeat (70) @(posedge clock);
        #1 chk("to_early", 32'(ferr_seen - f0), 32'd0);
        repeat (60) @(posedge clock);
        #1 chk("to_pulse", 32'(ferr_seen - f0), 32'd1);
        $display("timeout ferr=%0d wen=%0d", ferr_seen - f0, key_ram_wen);
        frame_check(8'h1C, 2'b00, 1'b1, 8'h61, 1'b0);

        // Reset in the middle of a frame while 'a' is held
        f0 = ferr_seen;
        send_bits(8'h45, 2'b00, 6, 1'b0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("midrst_wen", 32'(key_ram_wen), 32'd0);
        chk("midrst_wdata", key_ram_wdata, 32'd0);
        repeat (150) @(posedge clock);
        #1 chk("midrst_ferr", 32'(ferr_seen - f0), 32'd0);
        chk("midrst_wen_late", 32'(key_ram_wen), 32'd0);
        $display("midframe reset ferr=%0d wen=%0d", ferr_seen - f0, key_ram_wen);
        frame_check(8'h45, 2'b00, 1'b1, 8'h30, 1'b0);

        // Random key traffic against the reference model
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        model_reset();
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                k = $urandom_range(0, 37);
                if (k < 26)       code = letter_codes[k];
                else if (k < 36)  code = digit_codes[k - 26];
                else if (k == 36) code = 8'h29;
                else              code = 8'h5A;
            end else if (r < 60) begin
                code = m_held ? m_code : letter_codes[$urandom_range(0, 25)];
            end else if (r < 75) begin
                code = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
            end else begin
                k = $urandom_range(0, 3);
                code = (k == 0) ? 8'h0D : (k == 1) ? 8'h76 : (k == 2) ? 8'h05 : 8'h14;
            end
            brk = (r >= 45 && r < 60) || ($urandom_range(0, 3) == 0);
            ext = ($urandom_range(0, 9) == 0);
            seq.delete();
            if (ext) seq.push_back(8'hE0);
            if (brk) seq.push_back(8'hF0);
            seq.push_back(code);
            foreach (seq[j]) begin
                bad = ($urandom_range(0, 14) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                if (bad == 2'b00) model_feed(seq[j]);
                frame_check(seq[j], bad, m_held, m_held ? m_ascii : 8'h00, bad != 2'b00);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
